// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: hazard FSM states,
// the hard-wired zero register number and the default mult/div latency.
package mips_pipe_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MD_LAT_DEFAULT = 32;
    localparam int         MD_CNT_W       = 8;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks the multi-cycle mult/div unit: a start request holds busy high for
// exactly MD_LAT cycles. Requests while busy are ignored, never restarting the count.
module md_busy_timer
    import mips_pipe_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] LAT_M1 = MD_CNT_W'(MD_LAT - 1);

    hz_state_t             state_q, state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // The count runs MD_LAT-1 down to 0, so the busy state spans MD_LAT cycles.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = LAT_M1;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = '0;
            end
        endcase
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and mult/div
// dependency stalls. Optional performance counters are built with HAZARD_PERF_EN.
module hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_MemRd,
    input  logic             BranchTaken,
    input  logic             MDStart,
    input  logic             MDUse,
    output logic             PCWr,
    output logic             IFIDWr,
    output logic             IFIDrst,
    output logic             IDEXWr,
    output logic             IDEXrst,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             MDBusy
);

    logic load_hz;
    logic md_hz;
    logic md_busy;
    logic md_start;

    assign load_hz = IDEX_MemRd && (IDEX_Rt != REG_ZERO) &&
                     ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    assign md_hz   = md_busy && MDUse;

    // A wrong-path or stalled MD op must not launch the unit.
    assign md_start = MDStart && !BranchTaken && !load_hz && !md_busy;

    md_busy_timer #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_timer (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .busy  (md_busy)
    );

    assign MDBusy = md_busy;

    always_comb begin
        PCWr    = 1'b1;
        IFIDWr  = 1'b1;
        IFIDrst = 1'b0;
        IDEXWr  = 1'b1;
        IDEXrst = 1'b0;
        if (rst) begin
            PCWr   = 1'b0;
            IFIDWr = 1'b0;
            IDEXWr = 1'b0;
        end else if (BranchTaken) begin
            IFIDrst = 1'b1;
            IDEXrst = 1'b1;
        end else if (load_hz || md_hz) begin
            PCWr    = 1'b0;
            IFIDWr  = 1'b0;
            IDEXrst = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign stall_cnt_d = PCWr ? stall_cnt_q : stall_cnt_q + 1'b1;
    assign flush_cnt_d = BranchTaken ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit with MD_LAT=4: vector table plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_hazard_unit;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic [4:0] idexRt;
        logic       memRd;
        logic       branch;
        logic       mdStart;
        logic       mdUse;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [5:0] exp;
    } vec_t;

    // Output bits: {PCWr, IFIDWr, IFIDrst, IDEXWr, IDEXrst, MDBusy}
    localparam logic [5:0] NORM    = 6'b110100;
    localparam logic [5:0] STALL   = 6'b000110;
    localparam logic [5:0] FLUSH   = 6'b111110;
    localparam logic [5:0] NORM_B  = 6'b110101;
    localparam logic [5:0] STALL_B = 6'b000111;
    localparam logic [5:0] FLUSH_B = 6'b111111;
    localparam logic [5:0] RESET   = 6'b000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] IFID_Rs = '0, IFID_Rt = '0, IDEX_Rt = '0;
    logic       IFID_UsesRt = 1'b0, IDEX_MemRd = 1'b0, BranchTaken = 1'b0;
    logic       MDStart = 1'b0, MDUse = 1'b0;
    logic       PCWr, IFIDWr, IFIDrst, IDEXWr, IDEXrst, MDBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [5:0] expQ[$];
    string      tagQ[$];
    vec_t       vecs[8];

    always #5 clk = ~clk;

    hazard_unit #(
        .MD_LAT (4),
        .CNT_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IFID_Rs     (IFID_Rs),
        .IFID_Rt     (IFID_Rt),
        .IFID_UsesRt (IFID_UsesRt),
        .IDEX_Rt     (IDEX_Rt),
        .IDEX_MemRd  (IDEX_MemRd),
        .BranchTaken (BranchTaken),
        .MDStart     (MDStart),
        .MDUse       (MDUse),
        .PCWr        (PCWr),
        .IFIDWr      (IFIDWr),
        .IFIDrst     (IFIDrst),
        .IDEXWr      (IDEXWr),
        .IDEXrst     (IDEXrst),
`ifdef HAZARD_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .MDBusy      (MDBusy)
    );

    function automatic stim_t st(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic [4:0] idexRt, input logic memRd, input logic branch,
                                 input logic mdStart, input logic mdUse);
        stim_t s;
        s.rs = rs; s.rt = rt; s.usesRt = usesRt; s.idexRt = idexRt;
        s.memRd = memRd; s.branch = branch; s.mdStart = mdStart; s.mdUse = mdUse;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        IFID_Rs = s.rs; IFID_Rt = s.rt; IFID_UsesRt = s.usesRt; IDEX_Rt = s.idexRt;
        IDEX_MemRd = s.memRd; BranchTaken = s.branch; MDStart = s.mdStart; MDUse = s.mdUse;
    endtask

    task automatic checkOutput();
        logic [5:0] exp, act;
        string tag;
        total++;
        act = {PCWr, IFIDWr, IFIDrst, IDEXWr, IDEXrst, MDBusy};
        if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard empty: got %b, required an expected entry", act);
            return;
        end
        exp = expQ.pop_front();
        tag = tagQ.pop_front();
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b required %b (PCWr,IFIDWr,IFIDrst,IDEXWr,IDEXrst,MDBusy)",
                     tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s, input logic [5:0] exp, input string tag);
        @(posedge clk);
        #1;
        drive(s);
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkCount(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d required %0d", tag, act, exp);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0));
        expQ.push_back(RESET);
        tagQ.push_back("reset");
        #1;
        checkOutput();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t idle;
        idle = st(0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0] = '{st(5'd1, 5'd2, 1, 5'd7, 0, 0, 0, 0), NORM};
        vecs[1] = '{st(5'd5, 5'd2, 1, 5'd5, 1, 0, 0, 0), STALL};
        vecs[2] = '{st(5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0), NORM};
        vecs[3] = '{st(5'd3, 5'd5, 0, 5'd5, 1, 0, 0, 0), NORM};
        vecs[4] = '{st(5'd3, 5'd5, 1, 5'd5, 1, 0, 0, 0), STALL};
        vecs[5] = '{st(5'd5, 5'd5, 1, 5'd5, 0, 0, 0, 0), NORM};
        vecs[6] = '{st(5'd5, 5'd2, 1, 5'd5, 1, 1, 0, 0), FLUSH};
        vecs[7] = '{st(5'd9, 5'd9, 1, 5'd4, 0, 1, 0, 0), FLUSH};

        // Reset values while rst is held
        #2;
        expQ.push_back(RESET);
        tagQ.push_back("initial reset");
        checkOutput();
`ifdef HAZARD_PERF_EN
        checkCount("stall_cnt in reset", stall_cnt, 0);
        checkCount("flush_cnt in reset", flush_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].s, vecs[i].exp, $sformatf("vector %0d", i));
        end

        // Load-use stall lasts one cycle
        applyStimulus(st(5, 0, 0, 5, 1, 0, 0, 0), STALL, "load-use stall");
        applyStimulus(st(5, 0, 0, 5, 0, 0, 0, 0), NORM,  "load-use released");

        // Wrong-path or stalled MD start must not launch the unit
        applyStimulus(st(0, 0, 0, 0, 0, 1, 1, 1), FLUSH, "branch kills MDStart");
        applyStimulus(idle,                       NORM,  "no busy after killed start");
        applyStimulus(st(5, 0, 0, 5, 1, 0, 1, 1), STALL, "load_hz blocks MDStart");
        applyStimulus(idle,                       NORM,  "no busy after blocked start");

        // MD dependency: 4 busy cycles, restart attempt mid-way ignored
        applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 1), NORM,    "md start");
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1), STALL_B, "md busy 1");
        applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 1), STALL_B, "md busy 2 restart ignored");
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1), STALL_B, "md busy 3");
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1), STALL_B, "md busy 4");
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1), NORM,    "md dependent advances");
        applyStimulus(idle,                       NORM,    "md idle after");

        // Branch during busy flushes but the count continues
        applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 0), NORM,    "md start b");
        applyStimulus(idle,                       NORM_B,  "md busy b1");
        applyStimulus(st(0, 0, 0, 0, 0, 1, 1, 1), FLUSH_B, "branch in busy");
        applyStimulus(idle,                       NORM_B,  "md busy b3");
        applyStimulus(idle,                       NORM_B,  "md busy b4");
        applyStimulus(idle,                       NORM,    "md done b");

        // Reset in the second busy cycle aborts, then a full restart
        applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 0), NORM,   "md start r");
        applyStimulus(idle,                       NORM_B, "md busy r1");
        pulseReset();
        applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 0), NORM,   "restart after reset");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(idle, NORM_B, $sformatf("full restart busy %0d", i + 1));
        end
        applyStimulus(idle, NORM, "restart done");

`ifdef HAZARD_PERF_EN
        pulseReset();
        checkCount("stall_cnt after reset", stall_cnt, 0);
        checkCount("flush_cnt after reset", flush_cnt, 0);
        applyStimulus(st(5, 0, 0, 5, 1, 0, 0, 0), STALL, "perf load stall");
        applyStimulus(idle,                       NORM,  "perf normal");
        applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 1), NORM,  "perf md start");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1), STALL_B, $sformatf("perf md stall %0d", i + 1));
        end
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 1), NORM,  "perf md done");
        applyStimulus(st(0, 0, 0, 0, 0, 1, 0, 0), FLUSH, "perf branch 1");
        applyStimulus(st(0, 0, 0, 0, 0, 1, 0, 0), FLUSH, "perf branch 2");
        applyStimulus(idle,                       NORM,  "perf final");
        checkCount("stall_cnt", stall_cnt, 5);
        checkCount("flush_cnt", flush_cnt, 2);
`endif

        if (expQ.size() != 0) begin
            bad++;
            total++;
            $display("[TB] FAIL scoreboard leftover: got %0d entries required 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
